// File: rtl/ssd_pkg.sv
// Shared code and segment definitions for the multiplexed seven-segment display path.
// Segment vectors are active-low with bit0 = a through bit6 = g.
package ssd_pkg;

  typedef logic [3:0] code_t;
  typedef logic [6:0] seg_t;

  localparam code_t CODE_BLANK = 4'd10;
  localparam code_t CODE_DASH  = 4'd11;

  localparam seg_t SEG_OFF  = 7'h7F;
  localparam seg_t SEG_0    = 7'h40;
  localparam seg_t SEG_1    = 7'h79;
  localparam seg_t SEG_2    = 7'h24;
  localparam seg_t SEG_3    = 7'h30;
  localparam seg_t SEG_4    = 7'h19;
  localparam seg_t SEG_5    = 7'h12;
  localparam seg_t SEG_6    = 7'h02;
  localparam seg_t SEG_7    = 7'h78;
  localparam seg_t SEG_8    = 7'h00;
  localparam seg_t SEG_9    = 7'h10;
  localparam seg_t SEG_DASH = 7'h3F;

  // Codes 10 and 12..15 all render as an unlit digit.
  function automatic logic code_is_blank(input logic [3:0] code);
    return (code == CODE_BLANK) || (code >= 4'd12);
  endfunction

  function automatic logic code_is_zero_or_blank(input logic [3:0] code);
    return (code == 4'd0) || code_is_blank(code);
  endfunction

endpackage

// File: rtl/ssd_seg_decode.sv
// Combinational 4-bit display code to active-low seven-segment pattern.
module ssd_seg_decode
  import ssd_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      CODE_DASH: seg = SEG_DASH;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/ssd_result_display.sv
// Multiplexed common-anode seven-segment driver with value latch, clock-enable scan and
// post-load blink. Define SSD_LZ_SUPPRESS_EN to blank leading zeros on the upper digits.
module ssd_result_display
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 8192,
  parameter int BLINK_FRAMES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] in_value,
  input  logic                    in_valid,
  output logic [NUM_DIGITS-1:0]   DIGIT,
  output logic [6:0]              DISPLAY,
  output logic                    frame_done
);

  localparam int DIV_W       = $clog2(SCAN_DIV);
  localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLINK_W_RAW = $clog2(2 * BLINK_FRAMES + 1);
  localparam int BLINK_W     = (BLINK_W_RAW > 0) ? BLINK_W_RAW : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(2 * BLINK_FRAMES);

  logic [DIV_W-1:0]        div_cnt_reg, div_cnt_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [BLINK_W-1:0]      blink_cnt_reg, blink_cnt_next;
  logic [4*NUM_DIGITS-1:0] val_q_reg;
  logic                    tick, wrap;

  logic [3:0] digit_code [NUM_DIGITS];
  logic [3:0] shown_code [NUM_DIGITS];
  logic [3:0] sel_code;
  logic [6:0] sel_seg;

  assign tick = (div_cnt_reg == DIV_LAST);
  assign wrap = tick && (idx_reg == IDX_LAST);

  always_comb begin
    div_cnt_next = tick ? '0 : div_cnt_reg + 1'b1;
    idx_next     = idx_reg;
    if (tick) begin
      idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
    end
  end

  // A load restarts the blink sequence even if it coincides with a frame end.
  always_comb begin
    blink_cnt_next = blink_cnt_reg;
    if (in_valid) begin
      blink_cnt_next = BLINK_LOAD;
    end else if (wrap && (blink_cnt_reg != '0)) begin
      blink_cnt_next = blink_cnt_reg - 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign digit_code[gi] = val_q_reg[4*gi +: 4];
`ifndef SSD_LZ_SUPPRESS_EN
    assign shown_code[gi] = digit_code[gi];
`endif
  end

`ifdef SSD_LZ_SUPPRESS_EN
  // Walk from the most significant digit down; quiet stays set while all digits above are 0/blank.
  always_comb begin
    logic quiet;
    quiet = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      shown_code[i] = digit_code[i];
      if ((i != 0) && quiet && (digit_code[i] == 4'd0)) begin
        shown_code[i] = CODE_BLANK;
      end
      quiet = quiet && code_is_zero_or_blank(digit_code[i]);
    end
  end
`endif

  assign sel_code = shown_code[idx_next];

  ssd_seg_decode u_seg_decode (
    .code (sel_code),
    .seg  (sel_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_reg   <= '0;
      idx_reg       <= '0;
      blink_cnt_reg <= '0;
      val_q_reg     <= {NUM_DIGITS{CODE_BLANK}};
      DIGIT         <= '1;
      DISPLAY       <= SEG_OFF;
      frame_done    <= 1'b0;
    end else begin
      div_cnt_reg   <= div_cnt_next;
      idx_reg       <= idx_next;
      blink_cnt_reg <= blink_cnt_next;
      frame_done    <= wrap;
      if (in_valid) begin
        val_q_reg <= in_value;
      end
      // Display uses the pre-load value so a coincident load shows from the next tick on.
      if (tick) begin
        DIGIT   <= ~(NUM_DIGITS'(1) << idx_next);
        DISPLAY <= blink_cnt_next[0] ? SEG_OFF : sel_seg;
      end
    end
  end

endmodule

// File: tb/tb_ssd_result_display.sv
// Self-checking bench for ssd_result_display: directed scenarios plus random loads/resets,
// compared every cycle against a tick-counting reference model.
module tb_ssd_result_display;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int BF = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   in_value = '0;
  logic          in_valid = 1'b0;
  logic [N-1:0]  DIGIT;
  logic [6:0]    DISPLAY;
  logic          frame_done;

  int n_checks = 0;
  int n_errors = 0;

  ssd_result_display #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_value   (in_value),
    .in_valid   (in_valid),
    .DIGIT      (DIGIT),
    .DISPLAY    (DISPLAY),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: cycles since reset, ticks since reset, latched digits, blink frames left.
  int         m_cyc = 0;
  int         m_ticks = 0;
  int         m_val [N];
  int         m_blink = 0;
  logic [3:0] m_digit = 4'hF;
  logic [6:0] m_disp = 7'h7F;
  logic       m_fd = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int code);
    case (code)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  11: return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] model_seg(input int d);
    int code = m_val[d];
`ifdef SSD_LZ_SUPPRESS_EN
    bit lead = (d > 0) && (code == 0);
    for (int j = d + 1; j < N; j++)
      if (!(m_val[j] == 0 || m_val[j] == 10 || m_val[j] >= 12)) lead = 0;
    if (lead) return 7'h7F;
`endif
    return seg_of(code);
  endfunction

  task automatic model_edge(input bit r, input bit v, input logic [15:0] val);
    int d;
    if (r) begin
      m_cyc = 0; m_ticks = 0; m_blink = 0;
      for (int i = 0; i < N; i++) m_val[i] = 10;
      m_digit = 4'hF; m_disp = 7'h7F; m_fd = 1'b0;
      return;
    end
    m_fd = 1'b0;
    if (m_cyc % SD == SD - 1) begin
      m_ticks++;
      d = m_ticks % N;
      m_fd = (d == 0);
      if (m_fd && m_blink > 0) m_blink--;
      if (v) m_blink = 2 * BF;
      m_digit = ~(4'(1) << d);
      m_disp = (m_blink % 2 == 1) ? 7'h7F : model_seg(d);
    end else if (v) begin
      m_blink = 2 * BF;
    end
    if (v) for (int i = 0; i < N; i++) m_val[i] = int'(val[4*i +: 4]);
    m_cyc++;
  endtask

  task automatic step(input bit r, input bit v, input logic [15:0] val);
    @(negedge clk);
    rst = r; in_valid = v; in_value = val;
    if (v && !r) $display("load %04h at %0t", val, $time);
    @(posedge clk);
    model_edge(r, v, val);
    #1;
    check_eq("digit", 32'(DIGIT), 32'(m_digit));
    check_eq("display", 32'(DISPLAY), 32'(m_disp));
    check_eq("frame_done", 32'(frame_done), 32'(m_fd));
  endtask

  // Runs one full frame and records the segments shown on each anode.
  task automatic capture_frame(output logic [6:0] seen [N], output int fd_count);
    fd_count = 0;
    for (int i = 0; i < N; i++) seen[i] = 7'hxx;
    for (int c = 0; c < N * SD; c++) begin
      step(0, 0, 16'h0);
      fd_count += int'(frame_done);
      for (int i = 0; i < N; i++) if (DIGIT == ~(4'(1) << i)) seen[i] = DISPLAY;
    end
  endtask

  initial begin
    logic [6:0] seen [N];
    int fd_count;
    int n;
    logic [15:0] val;
    bit r, v;

    for (int i = 0; i < N; i++) m_val[i] = 10;

    // Reset and idle scan of blank digits.
    for (int i = 0; i < 3; i++) step(1, 0, 16'h0);
    check_eq("rst_digit", 32'(DIGIT), 32'hF);
    check_eq("rst_display", 32'(DISPLAY), 32'h7F);
    for (int i = 0; i < 2 * N * SD; i++) step(0, 0, 16'h0);

    // Plain load, run past blinking, then one steady frame.
    step(0, 1, 16'hAAA7);
    for (int i = 0; i < 6 * N * SD; i++) step(0, 0, 16'h0);
    capture_frame(seen, fd_count);
    check_eq("aaa7_d0", 32'(seen[0]), 32'h78);
    check_eq("aaa7_d1", 32'(seen[1]), 32'h7F);
    check_eq("aaa7_d3", 32'(seen[3]), 32'h7F);
    check_eq("fd_per_frame", 32'(fd_count), 32'd1);

    // Load coincident with the tick that wraps back to digit 0.
    step(0, 1, 16'h0003);
    for (int i = 0; i < 6 * N * SD; i++) step(0, 0, 16'h0);
    n = 0;
    while (!((m_cyc % SD == SD - 1) && (m_ticks % N == N - 1)) && n < 4 * N * SD) begin
      step(0, 0, 16'h0);
      n++;
    end
    step(0, 1, 16'h0005);
    check_eq("coinc_digit", 32'(DIGIT), 32'hE);
    check_eq("coinc_old", 32'(DISPLAY), 32'h30);
    for (int i = 0; i < 6 * N * SD; i++) step(0, 0, 16'h0);
    capture_frame(seen, fd_count);
    check_eq("coinc_new", 32'(seen[0]), 32'h12);

    // Leading zeros.
    step(0, 1, 16'h0042);
    for (int i = 0; i < 6 * N * SD; i++) step(0, 0, 16'h0);
    capture_frame(seen, fd_count);
`ifdef SSD_LZ_SUPPRESS_EN
    check_eq("lz_d3", 32'(seen[3]), 32'h7F);
    check_eq("lz_d2", 32'(seen[2]), 32'h7F);
`else
    check_eq("lz_d3", 32'(seen[3]), 32'h40);
    check_eq("lz_d2", 32'(seen[2]), 32'h40);
`endif
    check_eq("lz_d1", 32'(seen[1]), 32'h19);
    check_eq("lz_d0", 32'(seen[0]), 32'h24);

    // Reset while digit 2 is lit, then measure restart latency.
    n = 0;
    while (DIGIT != 4'b1011 && n < 4 * N * SD) begin
      step(0, 0, 16'h0);
      n++;
    end
    check_eq("found_idx2", 32'(DIGIT), 32'hB);
    step(1, 1, 16'h1234);
    check_eq("midrst_digit", 32'(DIGIT), 32'hF);
    check_eq("midrst_display", 32'(DISPLAY), 32'h7F);
    check_eq("midrst_fd", 32'(frame_done), 32'h0);
    n = 0;
    do begin
      step(0, 0, 16'h0);
      n++;
    end while (DIGIT == 4'hF && n < 20);
    check_eq("restart_lat", 32'(n), 32'(SD));
    check_eq("restart_digit", 32'(DIGIT), 32'hD);
    check_eq("restart_blank", 32'(DISPLAY), 32'h7F);

    // Random loads and occasional resets against the model.
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 499) == 0);
      v = ($urandom_range(0, 29) == 0);
      val = 16'($urandom);
      if ($urandom_range(0, 1) == 1) val[15:8] = 8'h00;
      step(r, v, val);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ssd_result_display.md
# ssd_result_display

Parametrised multiplexed seven-segment driver for the recognition result path. It latches a multi-digit code word on a valid pulse and scans NUM_DIGITS common-anode digits from an internal clock-enable divider, so no derived clock is needed. After each new value it optionally blinks for a set number of frames. It sits between `recog` and the board display pins and replaces the separate divided-clock display path.

## Interface
- `NUM_DIGITS`, 4: number of digits scanned; legal range 1–8.
- `SCAN_DIV`, 8192: clk cycles per scan tick; must be ≥2.
- `BLINK_FRAMES`, 0: number of frames blinked after each load; 0 disables blinking.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, synchronous and active-high.
- `in_value` in 4*NUM_DIGITS: digit codes; `[3:0]` is digit 0 (rightmost).
- `in_valid` in 1: single-cycle load strobe.
- `DIGIT` out NUM_DIGITS: anode enables, one-hot, active-low.
- `DISPLAY` out 7: segments, active-low; bit0 = a … bit6 = g.
- `frame_done` out 1: one-cycle pulse when a full scan frame completes.

## Operation
- Code map:
  - 0–9: decimal digit.
  - 10: blank.
  - 11: minus (segment g only).
  - 12–15: blank.
- Load: when `in_valid` is high, `in_value` is registered into `val_q` on that edge. `val_q` is held until the next load.
- Scan:
  - `div_cnt` counts 0..SCAN_DIV-1 and wraps.
  - `tick` is asserted when `div_cnt == SCAN_DIV-1`.
  - On `tick`, `idx` advances (NUM_DIGITS-1 wraps to 0).
  - `DIGIT` and `DISPLAY` are re-registered for the new `idx`.
- Frame end: `frame_done` pulses on the tick where `idx` wraps from NUM_DIGITS-1 to 0.
- Blink:
  - On load, `blink_cnt` is loaded with 2*BLINK_FRAMES.
  - `blink_cnt` decrements at each frame end while nonzero.
  - While `blink_cnt` is odd, `DISPLAY` is forced to 7'h7F and `DIGIT` still scans.
- Simultaneous load and tick: the new `val_q` takes effect at the next tick, not the coincident one. A load during blinking restarts the blink count.
- Widths:
  - `div_cnt` is $clog2(SCAN_DIV) bits.
  - `idx` is max(1,$clog2(NUM_DIGITS)) bits.
  - `blink_cnt` is $clog2(2*BLINK_FRAMES+1) bits, minimum 1.
- NUM_DIGITS=1: `idx` stays at 0 and `frame_done` pulses on every tick.

## Timing
- Reset values:
  - `DIGIT` all ones.
  - `DISPLAY` 7'h7F.
  - `frame_done` 0.
  - `val_q` all digits = 10 (blank).
  - `div_cnt`, `idx`, `blink_cnt` = 0.
- First post-reset tick: SCAN_DIV cycles after `rst` falls. It drives digit 1 (`idx` 0→1) with `DIGIT[1]` = 0.
- Outputs are registered. They change only on the cycle after a tick, i.e. a 1-cycle latency from `tick`.
- A load is visible on digit k no later than NUM_DIGITS*SCAN_DIV+1 cycles after `in_valid`.
- `rst` mid-frame: every register returns to its reset value on that edge and any pending load is discarded.

## Configuration
- `SSD_LZ_SUPPRESS_EN`
  - Defined: leading-zero suppression. For digits NUM_DIGITS-1 down to 1, a code 0 is shown blank if every more-significant digit is 0 or blank. Digit 0 is always shown.
  - Undefined: every code is shown literally per the code map.

## Structure
- Shared package `ssd_pkg`:
  - `CODE_BLANK` = 4'd10.
  - `CODE_DASH` = 4'd11.
  - `SEG_OFF` = 7'h7F.
  - Active-low segment constants for 0–9 and dash.
- Sub-module `ssd_seg_decode`: purely combinational, 4-bit code → 7-bit active-low segments. Instantiated once, on the muxed digit.
- Top level holds the divider, scan index, value latch, blink counter and the leading-zero suppression logic.

## Test plan
Bench parameters: NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
- Reset for 3 cycles, then release → `DIGIT`=4'hF and `DISPLAY`=7'h7F until the first tick. Each later tick shows a blank digit while `DIGIT` rotates 1110→1101→1011→0111.
- Load `in_value`=16'hAAA7 → once scanned and past the blink phase, digit 0 shows 7'h78 ("7") and digits 1–3 show 7'h7F. `frame_done` pulses every 16 cycles.
- Load, then count frames → blank, shown, blank, shown, then shown steadily. The blank frames have `DISPLAY`=7'h7F for all 16 cycles.
- Pulse `in_valid` on the same cycle as a tick with the value changing 0x0003→0x0005 → the coincident tick still displays the old digit and the next scan of digit 0 shows "5". Blinking restarts.
- Load 16'h0042 with the macro defined → digits 3 and 2 are blank, digits 1 and 0 show "4" and "2". Without the macro, digits 3 and 2 show "0" (7'h40).
- Assert `rst` mid-frame at `idx`=2 → the next cycle has all reset values and `val_q` is blank. The scan restarts SCAN_DIV cycles after release.
